mem_arbiter: RTL
================

# mem_arbiter

Sequencing arbiter that shares the single virtual memory bus of `mem_virtualizer` between the CPU instruction-fetch port and the load/store data port. It accepts one request at a time through a req/ack handshake and drives registered address, write data and write enable onto the virtual bus. It waits a fixed read latency, captures the read data and returns it to the granted requester. Data accesses have priority over fetches, and a starvation guard bounds how long a pending fetch can wait.

## Interface
- `MEM_LATENCY`, 1: cycles from the first cycle a read address is driven on the bus until `dataOutVirt` is valid (1..7).
- `STARVE_LIMIT`, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced (1..15).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-low reset.
- `fetchReq` in 1: fetch request, held until `fetchAck`.
- `fetchAddr` in 32: fetch address, stable while `fetchReq` is high.
- `fetchRdata` out 32: fetched word, valid only while `fetchAck` is high.
- `fetchAck` out 1: one-cycle completion pulse.
- `dataReq` in 1: load/store request, held until `dataAck`.
- `dataWe` in 1: 1 = store, 0 = load; stable with `dataReq`.
- `dataAddr` in 32: load/store address.
- `dataWdata` in 32: store data.
- `dataRdata` out 32: load result, valid only while `dataAck` is high.
- `dataAck` out 1: one-cycle completion pulse.
- `addressVirt` out 32: registered bus address, connects to `mem_virtualizer.addressVirt`.
- `dataInVirt` out 32: registered bus write data.
- `wEnVirt` out 1: registered bus write enable.
- `dataOutVirt` in 32: bus read data from `mem_virtualizer`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE:** samples the requests.
  - If neither request is high, stay in IDLE.
  - If only one is high, grant it.
  - If both are high, grant data, unless `starveCnt == STARVE_LIMIT`, in which case grant fetch.
  - On a grant, at the same edge: latch the address into `addressVirt`. For a store, also latch `dataWdata` into `dataInVirt` and set `wEnVirt`=1. Record the grant owner, clear `latCnt`, and go to ACCESS.
- **ACCESS, store:** `wEnVirt` is high for exactly the first ACCESS cycle and is cleared at the next edge. Go to DONE after that one cycle.
- **ACCESS, load or fetch:**
  - `latCnt` increments each cycle.
  - When `latCnt == MEM_LATENCY`, capture `dataOutVirt` into the owner's rdata register and go to DONE.
  - ACCESS therefore lasts MEM_LATENCY+1 cycles.
- **DONE:** the owner's ack is high for this one cycle. The rdata register holds its value. Always return to IDLE; requests are not sampled in DONE.
- **Starvation counter `starveCnt` (4 bits):**
  - Increments on each data grant made while `fetchReq` is high.
  - Clears on a fetch grant, or on any IDLE cycle with `fetchReq` low.
  - Saturates at STARVE_LIMIT.
- **Bus outputs:** `addressVirt`, `dataInVirt` and `dataOutVirt` capture are only meaningful in ACCESS. In IDLE and DONE, `addressVirt` and `dataInVirt` hold their last value and `wEnVirt` is 0.
- **Requester rule:** drop `req`, or present a new request, in the cycle after ack. A req still high in the IDLE cycle after DONE is treated as a new request, which gives back-to-back operation.
- A request that deasserts before its ack is a protocol violation. The grant completes anyway and the ack is still issued.

## Timing
- **Reset values** (applied at the rising edge with `rst`=0):
  - state IDLE; `busy`=0.
  - `addressVirt`, `dataInVirt` = 0; `wEnVirt` = 0.
  - `fetchAck`, `dataAck` = 0.
  - `fetchRdata`, `dataRdata` = 0.
  - `starveCnt`, `latCnt` = 0.
- **Reset mid-transaction:** the transaction is dropped with no ack, and `wEnVirt` is 0 from that edge.
- **Latency:** a grant sampled in IDLE at cycle T gives bus outputs valid in T+1.
  - Store: ack in T+2.
  - Load or fetch: rdata captured at the end of T+1+MEM_LATENCY, ack in T+2+MEM_LATENCY. This is T+3 for the default latency.
- **Throughput:**
  - Back-to-back stores: one every 3 cycles.
  - Back-to-back loads (default latency): one every 4 cycles.
- **Simultaneous requests:** in a single IDLE cycle exactly one is granted. The other waits, with its req held, and no ack is issued for it.
- At most one ack is high in any cycle, and never in two consecutive cycles.
- `busy` is combinational from state.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles mid-load → all outputs 0, no ack; after release `busy`=0.
- **Single load:** `dataReq`=1, `dataWe`=0, `dataAddr`=0x1000_0004, bus model returns 0xDEAD_BEEF one cycle after the address → `addressVirt`=0x1000_0004 in T+1, `dataAck`=1 with `dataRdata`=0xDEAD_BEEF in T+3, `wEnVirt` never 1.
- **Single store:** `dataWe`=1, `dataAddr`=0xFFFF_0002, `dataWdata`=0x0000_00A5 → `wEnVirt`=1 only in T+1 with matching address and data; `dataAck` in T+2.
- **Simultaneous requests:** both requests high in the same cycle, fetch addr 0x0000_0010 → data served first, fetch acked in the transaction immediately after; no fetch ack before the data ack.
- **Starvation:** `fetchReq` held high while data issues continuous back-to-back requests → exactly 4 data grants, then the fetch is granted, then data resumes.
- **Latency parameter:** MEM_LATENCY=3, single fetch → `fetchAck` in T+5 with the data present on `dataOutVirt` in T+4.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single virtual memory bus between the instruction
//               fetch port and the load/store data port. One request is
//               served at a time; data wins over fetch unless a pending fetch
//               has been passed over STARVE_LIMIT times in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        fetchReq_i,
  input  logic [31:0] fetchAddr_i,
  output logic [31:0] fetchRdata_o,
  output logic        fetchAck_o,
  // load/store port
  input  logic        dataReq_i,
  input  logic        dataWe_i,
  input  logic [31:0] dataAddr_i,
  input  logic [31:0] dataWdata_i,
  output logic [31:0] dataRdata_o,
  output logic        dataAck_o,
  // virtual memory bus
  output logic [31:0] addressVirt_o,
  output logic [31:0] dataInVirt_o,
  output logic        wEnVirt_o,
  input  logic [31:0] dataOutVirt_i,
  // status
  output logic        busy_o
);

  localparam logic [2:0] LAT_C    = 3'(MEM_LATENCY);
  localparam logic [3:0] STARVE_C = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      state_q,      state_d;
  logic        ownerData_q,  ownerData_d;   // 1 = data port owns the bus
  logic        isStore_q,    isStore_d;
  logic [2:0]  latCnt_q,     latCnt_d;
  logic [3:0]  starveCnt_q,  starveCnt_d;
  logic [31:0] addr_q,       addr_d;
  logic [31:0] wdata_q,      wdata_d;
  logic        wEn_q,        wEn_d;
  logic [31:0] fetchRdata_q, fetchRdata_d;
  logic [31:0] dataRdata_q,  dataRdata_d;

  logic starved;
  logic grantFetch;
  logic grantData;

  // Arbitration: data first, except when the fetch has waited too long.
  always_comb begin
    starved    = (starveCnt_q == STARVE_C);
    grantFetch = fetchReq_i && (!dataReq_i || starved);
    grantData  = dataReq_i && !grantFetch;
  end

  // Next-state and datapath decode for the IDLE/ACCESS/DONE sequence.
  always_comb begin
    state_d      = state_q;
    ownerData_d  = ownerData_q;
    isStore_d    = isStore_q;
    latCnt_d     = latCnt_q;
    starveCnt_d  = starveCnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wEn_d        = 1'b0;   // write strobe lasts only the first ACCESS cycle
    fetchRdata_d = fetchRdata_q;
    dataRdata_d  = dataRdata_q;

    case (state_q)
      S_IDLE: begin
        // A fetch that is not waiting has nothing to be starved of.
        if (!fetchReq_i) begin
          starveCnt_d = 4'd0;
        end
        if (grantFetch) begin
          ownerData_d = 1'b0;
          isStore_d   = 1'b0;
          addr_d      = fetchAddr_i;
          latCnt_d    = 3'd0;
          starveCnt_d = 4'd0;
          state_d     = S_ACCESS;
        end else if (grantData) begin
          ownerData_d = 1'b1;
          isStore_d   = dataWe_i;
          addr_d      = dataAddr_i;
          latCnt_d    = 3'd0;
          if (dataWe_i) begin
            wdata_d = dataWdata_i;
            wEn_d   = 1'b1;
          end
          // Count data grants that overtook a waiting fetch; saturating.
          if (fetchReq_i && !starved) begin
            starveCnt_d = starveCnt_q + 4'd1;
          end
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (isStore_q) begin
          state_d = S_DONE;
        end else if (latCnt_q == LAT_C) begin
          // Read data is valid now; route it to whoever owns the bus.
          if (ownerData_q) begin
            dataRdata_d = dataOutVirt_i;
          end else begin
            fetchRdata_d = dataOutVirt_i;
          end
          state_d = S_DONE;
        end else begin
          latCnt_d = latCnt_q + 3'd1;
        end
      end

      S_DONE: begin
        // Requests are deliberately ignored here so the requester has a
        // cycle to drop or replace its request after the ack.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ownerData_q  <= 1'b0;
      isStore_q    <= 1'b0;
      latCnt_q     <= 3'd0;
      starveCnt_q  <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wEn_q        <= 1'b0;
      fetchRdata_q <= 32'd0;
      dataRdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      ownerData_q  <= ownerData_d;
      isStore_q    <= isStore_d;
      latCnt_q     <= latCnt_d;
      starveCnt_q  <= starveCnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wEn_q        <= wEn_d;
      fetchRdata_q <= fetchRdata_d;
      dataRdata_q  <= dataRdata_d;
    end
  end

  // Output mapping: acks and busy decode directly from the state register.
  always_comb begin
    addressVirt_o = addr_q;
    dataInVirt_o  = wdata_q;
    wEnVirt_o     = wEn_q;
    fetchRdata_o  = fetchRdata_q;
    dataRdata_o   = dataRdata_q;
    fetchAck_o    = (state_q == S_DONE) && !ownerData_q;
    dataAck_o     = (state_q == S_DONE) &&  ownerData_q;
    busy_o        = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire
